// File: rtl/latch_bank_wr_ctrl.sv
// Write/clear sequencer for a latrsnq latch bank: setup -> E pulse -> hold, plus clear with RN recovery.
// Optional preset path (SETN sequencing, preset_req port) is enabled by defining LATBANK_PRESET_EN.
module latch_bank_wr_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
`ifdef LATBANK_PRESET_EN
    input  logic             preset_req,
`endif
    output logic             busy,
    output logic             addr_err,
    output logic [WIDTH-1:0] lat_d,
    output logic [DEPTH-1:0] lat_e,
    output logic             lat_rn,
    output logic             lat_setn
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        CLEAR,
        RECOV,
        IDLE,
        SETUP,
        PULSE,
        HOLD
`ifdef LATBANK_PRESET_EN
        , PRESET
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DEPTH-1:0] lat_e_q, lat_e_d;
    logic             addr_err_q, addr_err_d;
    logic             lat_rn_q, lat_rn_d;
    logic             lat_setn_q, lat_setn_d;
    logic             busy_q, busy_d;
    logic [DEPTH-1:0] addr_dec;
    logic             hold_off;

    // Out-of-range addresses decode to all-zero, which also flags addr_err.
    always_comb begin
        addr_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_dec[i] = (addr_q == AW'(i));
        end
    end

`ifdef LATBANK_PRESET_EN
    assign hold_off = clr_req | preset_req;
`else
    assign hold_off = clr_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        lat_d_d    = lat_d_q;
        addr_d     = addr_q;
        lat_e_d    = lat_e_q;
        addr_err_d = 1'b0;
        case (state_q)
            CLEAR: begin
                if (cnt_q == CW'(CLR_CYC - 1)) begin
                    state_d = RECOV;
                    cnt_d   = '0;
                end
            end
`ifdef LATBANK_PRESET_EN
            PRESET: begin
                if (cnt_q == CW'(CLR_CYC - 1)) begin
                    state_d = RECOV;
                    cnt_d   = '0;
                end
            end
`endif
            RECOV: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            IDLE: begin
                cnt_d = '0;
                if (clr_req) begin
                    state_d = CLEAR;
`ifdef LATBANK_PRESET_EN
                end else if (preset_req) begin
                    state_d = PRESET;
`endif
                end else if (wr_valid) begin
                    state_d = SETUP;
                    lat_d_d = wr_data;
                    addr_d  = wr_addr;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d    = PULSE;
                    cnt_d      = '0;
                    lat_e_d    = addr_dec;
                    addr_err_d = ~|addr_dec;
                end
            end
            PULSE: begin
                if (cnt_q == CW'(PULSE_CYC - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    lat_e_d = '0;
                end
            end
            HOLD: begin
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                lat_e_d = '0;
            end
        endcase
        lat_rn_d = (state_d != CLEAR);
`ifdef LATBANK_PRESET_EN
        lat_setn_d = (state_d != PRESET);
`else
        lat_setn_d = 1'b1;
`endif
        busy_d = (state_d != IDLE);
    end

    // Async reset drops lat_e at once so a reset mid-pulse never races the latch RN.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            lat_d_q    <= '0;
            addr_q     <= '0;
            lat_e_q    <= '0;
            addr_err_q <= 1'b0;
            lat_rn_q   <= 1'b0;
            lat_setn_q <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_d_q    <= lat_d_d;
            addr_q     <= addr_d;
            lat_e_q    <= lat_e_d;
            addr_err_q <= addr_err_d;
            lat_rn_q   <= lat_rn_d;
            lat_setn_q <= lat_setn_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_ready = ~busy_q & ~hold_off;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;
    assign lat_d    = lat_d_q;
    assign lat_e    = lat_e_q;
    assign lat_rn   = lat_rn_q;
    assign lat_setn = lat_setn_q;

endmodule

// File: doc/latch_bank_wr_ctrl.md
Name: latch_bank_wr_ctrl

Overview:
- Write controller that sits directly upstream of a bank of DEPTH words built from latrsnq latch cells (latch with active-low reset and set).
- Accepts valid/ready write requests and drives the shared latch D bus and a one-hot per-word E.
- Sequences each write as setup, then enable pulse, then hold, so latch setup/hold/min-width checks are met by construction.
- Also sequences bank-wide clear on the shared RN, with a recovery cycle before any E pulse.

Parameters:
- WIDTH, 8, data bits per latch word.
- DEPTH, 4, number of latch words; AW = max(1, clog2(DEPTH)) is a derived localparam.
- SETUP_CYC, 1, cycles D is stable before E rises (≥1).
- PULSE_CYC, 1, cycles E is high (≥1).
- HOLD_CYC, 1, cycles D is held after E falls (≥1).
- CLR_CYC, 2, cycles lat_rn is held low per clear (≥1).

Ports:
- CLK, input, 1, clock; all state updates on rising edge.
- RN, input, 1, asynchronous active-low reset.
- wr_valid, input, 1, write request valid.
- wr_ready, output, 1, controller can accept a write.
- wr_addr, input, AW, target word index.
- wr_data, input, WIDTH, write data.
- clr_req, input, 1, level request for a bank clear.
- busy, output, 1, high in every state except IDLE.
- addr_err, output, 1, one-cycle pulse when an out-of-range address is accepted.
- lat_d, output, WIDTH, shared latch D bus.
- lat_e, output, DEPTH, one-hot latch enables.
- lat_rn, output, 1, shared latch RN.
- lat_setn, output, 1, shared latch SETN.

Behaviour:
- All outputs are driven directly from flops; there are no combinational paths to lat_*.
- Reset, while RN=0:
  - lat_e=0, lat_d=0, lat_rn=0, lat_setn=1.
  - wr_ready=0, busy=1, addr_err=0.
  - state=CLEAR, counter=0.
- Reset can assert at any point, including mid-sequence. It aborts the sequence immediately and drives lat_e low asynchronously.
- FSM states: CLEAR, RECOV, IDLE, SETUP, PULSE, HOLD.
- CLEAR:
  - lat_rn=0 for CLR_CYC cycles, counted from the first rising edge after RN deasserts, or from entry.
  - Then go to RECOV.
- RECOV:
  - One cycle with lat_rn=1 and lat_e=0, to meet the latch RN-to-E recovery requirement.
  - Then go to IDLE.
- IDLE:
  - wr_ready = ~clr_req.
  - If clr_req=1, go to CLEAR. Clear has priority over a simultaneous wr_valid; no write is accepted that cycle.
  - Otherwise, if wr_valid=1, accept the write: capture wr_data into lat_d and the address into an internal register, then go to SETUP.
- SETUP:
  - Lasts SETUP_CYC cycles; lat_d is held.
  - At the last edge, lat_e[addr] is set to 1, then go to PULSE.
  - If addr ≥ DEPTH, lat_e stays all-zero and addr_err pulses high for 1 cycle, coincident with the cycle E would have risen.
- PULSE:
  - Lasts PULSE_CYC cycles with lat_e one-hot.
  - At the last edge, lat_e is cleared, then go to HOLD.
- HOLD:
  - Lasts HOLD_CYC cycles; lat_d is held.
  - Then go to IDLE.
  - lat_d keeps its last value in IDLE; it is not zeroed.
- Latency: accept edge to E rise = SETUP_CYC edges. Accept edge to wr_ready high again = SETUP_CYC+PULSE_CYC+HOLD_CYC edges.
- clr_req during SETUP/PULSE/HOLD:
  - The write completes unchanged.
  - The clear is taken from IDLE on the following cycle, provided clr_req is still high (level, not latched).
- wr_valid without wr_ready is ignored; wr_data and wr_addr are don't-care while wr_ready=0.
- At most one bit of lat_e is ever high, and it is high only while lat_rn=1 and lat_setn=1.

Optional Feature:
- Macro: LATBANK_PRESET_EN.
- When defined:
  - Adds input preset_req (1 bit) and state PRESET.
  - In IDLE, priority is clr_req > preset_req > wr_valid.
  - PRESET drives lat_setn=0 for CLR_CYC cycles, then goes to RECOV.
  - RECOV in this path has lat_setn=1 and lat_e=0.
  - wr_ready = ~clr_req & ~preset_req in IDLE.
- When not defined:
  - No preset_req port.
  - lat_setn is a constant 1 flop output (reset value 1).

Test Plan:
- Reset release with defaults: lat_rn=0 for 2 cycles after RN rises, then 1 cycle of RECOV, then wr_ready=1 on the 4th edge; lat_e=0 throughout.
- Write addr=2, data=0xA5: lat_d=0xA5 at the accept edge; lat_e=4'b0100 for exactly 1 cycle starting 1 edge later; lat_d still 0xA5 one cycle after E falls; wr_ready=1 three edges after accept.
- clr_req and wr_valid both high in IDLE: no accept (wr_ready=0); lat_rn=0 for 2 cycles then RECOV; the write is accepted afterwards when wr_valid is held.
- clr_req asserted during PULSE of a write to addr=1: lat_e=4'b0010 completes its full width; lat_rn falls only after HOLD and IDLE; lat_e and lat_rn are never both active.
- DEPTH=3, write addr=3: accepted; addr_err=1 for 1 cycle; lat_e stays 0; busy=1 for 3 cycles.
- RN pulled low mid-PULSE: lat_e clears asynchronously and lat_rn=0 immediately; the CLEAR sequence restarts after RN rises.
